// File: rtl/somatorio_pkg.sv
// rtl/somatorio_pkg.sv - shared state encoding, default sizes and operand slice helper
package somatorio_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_N_OPS = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    FIRST = 3'd2,
    SEND  = 3'd3,
    WAIT  = 3'd4,
    DONE  = 3'd5
  } state_t;

  // op0 sits in the MSBs of the packed operand vector
  function automatic logic [DEF_WIDTH-1:0] op_at(input logic [DEF_N_OPS*DEF_WIDTH-1:0] ops,
                                                 input int unsigned idx);
    return ops[(DEF_N_OPS-1-idx)*DEF_WIDTH +: DEF_WIDTH];
  endfunction

endpackage

// File: rtl/somatorio_if.sv
// rtl/somatorio_if.sv - iniciar/ent -> soma/pronto/erro link between initiator and datapath
interface somatorio_if #(
  parameter int WIDTH = 8
);
  logic             iniciar;
  logic [WIDTH-1:0] ent;
  logic [WIDTH-1:0] soma;
  logic             pronto;
  logic             erro;

  modport master (output iniciar, output ent, input soma, input pronto, input erro);
  modport slave  (input iniciar, input ent, output soma, output pronto, output erro);
endinterface

// File: rtl/somatorio_timeout_ctr.sv
// rtl/somatorio_timeout_ctr.sv - WAIT-state timeout counter with load/enable/expire
module somatorio_timeout_ctr #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic expire
);
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (en && !expire) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expire = en && (count == CNT_W'(TIMEOUT_CYC - 1));
endmodule

// File: rtl/somatorio_mestre.sv
// rtl/somatorio_mestre.sv - somatorio initiator; optional res_mis check under SOMATORIO_SELF_CHECK_EN
module somatorio_mestre
  import somatorio_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int N_OPS       = DEF_N_OPS,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [N_OPS*WIDTH-1:0] ops,
  output logic                   busy,
  output logic                   done,
  output logic [WIDTH-1:0]       res_sum,
  output logic                   res_ovf,
  output logic                   res_tmo,
`ifdef SOMATORIO_SELF_CHECK_EN
  output logic                   res_mis,
`endif
  somatorio_if.master            bus
);
  localparam int IDX_W = $clog2(N_OPS);

  state_t                 state, next_state;
  logic [IDX_W-1:0]       idx;
  logic [N_OPS*WIDTH-1:0] op_reg;
  logic [WIDTH-1:0]       op_head;
  logic                   last_op;
  logic                   accept, shift;
  logic                   tmo_load, tmo_en, tmo_expire;
  logic                   iniciar_d, busy_d, done_d;
  logic [WIDTH-1:0]       ent_d;

  assign op_head = op_reg[N_OPS*WIDTH-1 -: WIDTH];
  assign last_op = (idx == IDX_W'(N_OPS - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = INIT;
      INIT:    next_state = FIRST;
      FIRST:   next_state = SEND;
      SEND:    if (last_op) next_state = WAIT;
      WAIT:    if (bus.erro || bus.pronto || tmo_expire) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs are decoded from next_state and registered, so they line up with the state they describe
  always_comb begin
    accept    = (state == IDLE) && (next_state == INIT);
    shift     = (next_state == FIRST) || (next_state == SEND);
    tmo_load  = (state == SEND) && (next_state == WAIT);
    tmo_en    = (state == WAIT);
    iniciar_d = (next_state == INIT) || (next_state == FIRST);
    busy_d    = (next_state != IDLE) && (next_state != DONE);
    done_d    = (next_state == DONE);
    case (next_state)
      FIRST, SEND: ent_d = op_head;
      WAIT:        ent_d = bus.ent;
      default:     ent_d = '0;
    endcase
  end

  somatorio_timeout_ctr #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .load   (tmo_load),
    .en     (tmo_en),
    .expire (tmo_expire)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.iniciar <= 1'b0;
      bus.ent     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      op_reg      <= '0;
      idx         <= '0;
      res_sum     <= '0;
      res_ovf     <= 1'b0;
      res_tmo     <= 1'b0;
    end else begin
      bus.iniciar <= iniciar_d;
      bus.ent     <= ent_d;
      busy        <= busy_d;
      done        <= done_d;

      if (accept) begin
        op_reg  <= ops;
        res_ovf <= 1'b0;
        res_tmo <= 1'b0;
      end else if (shift) begin
        op_reg <= op_reg << WIDTH;
      end

      if (state == FIRST) idx <= IDX_W'(1);
      else if (state == SEND && !last_op) idx <= idx + IDX_W'(1);

      // erro outranks pronto; a timeout leaves res_sum untouched
      if (state == WAIT) begin
        if (bus.erro) begin
          res_sum <= bus.soma;
          res_ovf <= 1'b1;
        end else if (bus.pronto) begin
          res_sum <= bus.soma;
          res_ovf <= 1'b0;
        end else if (tmo_expire) begin
          res_tmo <= 1'b1;
        end
      end
    end
  end

`ifdef SOMATORIO_SELF_CHECK_EN
  localparam int ACC_W = WIDTH + $clog2(N_OPS);

  logic [ACC_W-1:0] ref_acc;
  logic             ref_ovf;

  assign ref_ovf = |ref_acc[ACC_W-1:WIDTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      ref_acc <= '0;
      res_mis <= 1'b0;
    end else begin
      if (accept) begin
        ref_acc <= '0;
        res_mis <= 1'b0;
      end else if (shift) begin
        ref_acc <= ref_acc + ACC_W'(op_head);
      end
      if (state == WAIT) begin
        if (bus.erro)        res_mis <= !ref_ovf;
        else if (bus.pronto) res_mis <= (bus.soma != ref_acc[WIDTH-1:0]) || ref_ovf;
        else if (tmo_expire) res_mis <= 1'b0;
      end
    end
  end
`endif

endmodule
